// File: rtl/uart_host_pkg.sv
// Shared constants, frame lengths and FSM encodings for the UART host controller.
// Signal bytes are ASCII command/header characters exchanged with the remote device.
package uart_host_pkg;

  localparam logic [7:0] SIG_M_UP = 8'h4D;  // 'M'
  localparam logic [7:0] SIG_M_LO = 8'h6D;  // 'm'
  localparam logic [7:0] SIG_A_UP = 8'h41;  // 'A'
  localparam logic [7:0] SIG_A_LO = 8'h61;  // 'a'
  localparam logic [7:0] SIG_R    = 8'h52;  // 'R'
  localparam logic [7:0] SIG_S    = 8'h53;  // 'S'
  localparam logic [7:0] SIG_F_UP = 8'h46;  // 'F'
  localparam logic [7:0] SIG_F_LO = 8'h66;  // 'f'

  localparam logic [2:0] FRAME_LEN_LONG  = 3'd5;
  localparam logic [2:0] FRAME_LEN_SHORT = 3'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT, TX_NEXT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_BODY, RX_DONE} rx_state_t;

  // Number of bytes a command puts on the wire; 0 means the command is dropped.
  function automatic logic [1:0] cmd_len(input logic [7:0] sig);
    case (sig)
      SIG_R, SIG_S, SIG_F_UP, SIG_F_LO: cmd_len = 2'd1;
      SIG_M_LO, SIG_A_LO:               cmd_len = 2'd2;
      default:                          cmd_len = 2'd0;
    endcase
  endfunction

  // Total frame length implied by a header byte; 0 means unknown header.
  function automatic logic [2:0] header_len(input logic [7:0] hdr);
    case (hdr)
      SIG_A_UP:                     header_len = FRAME_LEN_LONG;
      SIG_M_UP, SIG_M_LO, SIG_A_LO: header_len = FRAME_LEN_SHORT;
      default:                      header_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/uart_host_frame_rx.sv
// Receive-side frame assembler: header byte selects frame length, bytes pack MSB-first.
// Optional inter-byte timeout enabled by defining UART_HOST_RX_TIMEOUT_EN.
module uart_host_frame_rx
  import uart_host_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2700
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [39:0] frame,
  output logic        frame_valid,
  output logic        rx_err
);

  rx_state_t   state_q, state_d;
  logic [2:0]  cnt_q, len_q, hdr_len;
  logic [39:0] buf_q;
  logic        hdr_take, body_take, frame_end, err_set;

  function automatic logic [39:0] place_byte(input logic [7:0] b, input logic [2:0] idx);
    case (idx)
      3'd0:    place_byte = {b, 32'd0};
      3'd1:    place_byte = {8'd0, b, 24'd0};
      3'd2:    place_byte = {16'd0, b, 16'd0};
      3'd3:    place_byte = {24'd0, b, 8'd0};
      3'd4:    place_byte = {32'd0, b};
      default: place_byte = 40'd0;
    endcase
  endfunction

`ifdef UART_HOST_RX_TIMEOUT_EN
  logic [15:0] tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign hdr_len = header_len(rx_byte);

  always_comb begin
    state_d   = state_q;
    hdr_take  = 1'b0;
    body_take = 1'b0;
    frame_end = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      RX_IDLE, RX_DONE: begin
        // A byte landing in RX_DONE is already the next header.
        state_d = RX_IDLE;
        if (rx_valid) begin
          if (hdr_len != 3'd0) begin
            hdr_take = 1'b1;
            state_d  = RX_BODY;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RX_BODY: begin
        if (rx_valid) begin
          body_take = 1'b1;
          if (cnt_q + 3'd1 == len_q) begin
            frame_end = 1'b1;
            state_d   = RX_DONE;
          end
        end
`ifdef UART_HOST_RX_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
          err_set = 1'b1;
          state_d = RX_IDLE;
        end
`endif
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      frame       <= 40'd0;
      frame_valid <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_valid <= frame_end;
      rx_err      <= err_set;
      if (hdr_take) begin
        cnt_q <= 3'd1;
        len_q <= hdr_len;
      end else if (body_take && cnt_q < len_q) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (frame_end)
        frame <= buf_q | place_byte(rx_byte, cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_take)
      buf_q <= place_byte(rx_byte, 3'd0);
    else if (body_take)
      buf_q <= buf_q | place_byte(rx_byte, cnt_q);
  end

`ifdef UART_HOST_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_q <= 16'd0;
    else if (hdr_take || body_take || state_q != RX_BODY)
      tmo_q <= 16'd0;
    else
      tmo_q <= tmo_q + 16'd1;
  end
`endif

endmodule

// File: rtl/uart_host_controller.sv
// Full-duplex UART host: TX command sequencer here, RX frame assembly in uart_host_frame_rx.
// Define UART_HOST_RX_TIMEOUT_EN to enable the RX inter-byte timeout.
module uart_host_controller
  import uart_host_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2700
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic [15:0] i_CMD,
  input  logic        i_CMD_VALID,
  output logic        o_CMD_READY,
  output logic [7:0]  o_TX_BYTE,
  output logic        o_TX_BYTE_VALID,
  input  logic        i_TX_DONE,
  input  logic [7:0]  i_RX_BYTE,
  input  logic        i_RX_BYTE_VALID,
  output logic [39:0] o_FRAME,
  output logic        o_FRAME_VALID,
  output logic        o_RX_ERR,
  output logic        o_STREAMING
);

  tx_state_t  tx_state_q, tx_state_d;
  logic       ready_q, load, done_more, done_last;
  logic       second_pending, first_byte, streaming_q;
  logic [7:0] tx_byte_q, addr_q;
  logic [1:0] len;

  assign len = cmd_len(i_CMD[15:8]);

  always_comb begin
    tx_state_d = tx_state_q;
    load       = 1'b0;
    done_more  = 1'b0;
    done_last  = 1'b0;
    case (tx_state_q)
      TX_IDLE:
        // Unknown signals are consumed but keep the FSM idle.
        if (i_CMD_VALID && ready_q && len != 2'd0) begin
          load       = 1'b1;
          tx_state_d = TX_SEND;
        end
      TX_SEND: tx_state_d = TX_WAIT;
      TX_WAIT:
        if (i_TX_DONE) begin
          if (second_pending) begin
            done_more  = 1'b1;
            tx_state_d = TX_SEND;
          end else begin
            done_last  = 1'b1;
            tx_state_d = TX_NEXT;
          end
        end
      TX_NEXT: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      tx_state_q     <= TX_IDLE;
      ready_q        <= 1'b0;
      tx_byte_q      <= 8'd0;
      second_pending <= 1'b0;
      first_byte     <= 1'b0;
      streaming_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      ready_q    <= (tx_state_d == TX_IDLE);
      if (load) begin
        tx_byte_q      <= i_CMD[15:8];
        second_pending <= (len == 2'd2);
        first_byte     <= 1'b1;
      end else if (done_more) begin
        tx_byte_q      <= addr_q;
        second_pending <= 1'b0;
        first_byte     <= 1'b0;
      end
      if ((done_more || done_last) && first_byte) begin
        if (tx_byte_q == SIG_R)
          streaming_q <= 1'b1;
        else if (tx_byte_q == SIG_S)
          streaming_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (load)
      addr_q <= i_CMD[7:0];
  end

  assign o_CMD_READY     = ready_q;
  assign o_TX_BYTE       = tx_byte_q;
  assign o_TX_BYTE_VALID = (tx_state_q == TX_SEND);
  assign o_STREAMING     = streaming_q;

  uart_host_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (i_CLK),
    .rst_n      (i_RSTN),
    .rx_byte    (i_RX_BYTE),
    .rx_valid   (i_RX_BYTE_VALID),
    .frame      (o_FRAME),
    .frame_valid(o_FRAME_VALID),
    .rx_err     (o_RX_ERR)
  );

endmodule

// File: tb/tb_uart_host_controller.sv
// Directed self-checking bench for uart_host_controller (TX sequencing, RX framing, reset).
module tb_uart_host_controller;

  localparam logic [15:0] TMO = 16'd2700;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_done;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [39:0] frame;
  logic        frame_valid;
  logic        rx_err;
  logic        streaming;

  int total = 0;
  int bad   = 0;
  int fv_count  = 0;
  int err_count = 0;
  int fv_before;
  int err_before;

  always #5 clk = ~clk;

  uart_host_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_CLK          (clk),
    .i_RSTN         (rstn),
    .i_CMD          (cmd),
    .i_CMD_VALID    (cmd_valid),
    .o_CMD_READY    (cmd_ready),
    .o_TX_BYTE      (tx_byte),
    .o_TX_BYTE_VALID(tx_valid),
    .i_TX_DONE      (tx_done),
    .i_RX_BYTE      (rx_byte),
    .i_RX_BYTE_VALID(rx_valid),
    .o_FRAME        (frame),
    .o_FRAME_VALID  (frame_valid),
    .o_RX_ERR       (rx_err),
    .o_STREAMING    (streaming)
  );

  always @(posedge clk) begin
    if (frame_valid) fv_count++;
    if (rx_err) err_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic issue_cmd(input logic [15:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(cmd_ready), 64'd0);
    check({tag, "_txb"},   64'(tx_byte), 64'd0);
    check({tag, "_txv"},   64'(tx_valid), 64'd0);
    check({tag, "_frame"}, 64'(frame), 64'd0);
    check({tag, "_fv"},    64'(frame_valid), 64'd0);
    check({tag, "_err"},   64'(rx_err), 64'd0);
    check({tag, "_strm"},  64'(streaming), 64'd0);
  endtask

  initial begin
    rstn = 1'b0; cmd = 16'd0; cmd_valid = 1'b0; tx_done = 1'b0;
    rx_byte = 8'd0; rx_valid = 1'b0;
    repeat (3) tick();
    check_all_zero("rst");
    rstn = 1'b1;
    tick();
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // 'R': single byte, streaming goes high on its done
    issue_cmd(16'h5200);
    check("R_txv", 64'(tx_valid), 64'd1);
    check("R_txb", 64'(tx_byte), 64'h52);
    check("R_busy", 64'(cmd_ready), 64'd0);
    tick();
    check("R_txv_once", 64'(tx_valid), 64'd0);
    repeat (268) tick();
    check("R_hold", 64'(tx_byte), 64'h52);
    check("R_strm_pre", 64'(streaming), 64'd0);
    pulse_done();
    check("R_strm", 64'(streaming), 64'd1);
    tick();
    check("R_ready", 64'(cmd_ready), 64'd1);
    pulse_done();
    check("done_idle_txv", 64'(tx_valid), 64'd0);
    check("done_idle_strm", 64'(streaming), 64'd1);

    // 'm' + address: done during TX_SEND is ignored
    issue_cmd(16'h6D1A);
    check("m_txv1", 64'(tx_valid), 64'd1);
    check("m_txb1", 64'(tx_byte), 64'h6D);
    pulse_done();
    check("m_early_done", 64'(tx_byte), 64'h6D);
    check("m_wait_txv", 64'(tx_valid), 64'd0);
    repeat (5) tick();
    pulse_done();
    check("m_txv2", 64'(tx_valid), 64'd1);
    check("m_txb2", 64'(tx_byte), 64'h1A);
    tick();
    check("m_txv2_once", 64'(tx_valid), 64'd0);
    pulse_done();
    tick();
    check("m_ready", 64'(cmd_ready), 64'd1);
    check("m_strm", 64'(streaming), 64'd1);

    // unknown signal dropped
    issue_cmd(16'h5800);
    check("drop_txv", 64'(tx_valid), 64'd0);
    check("drop_ready", 64'(cmd_ready), 64'd1);

    // 'S' clears streaming
    issue_cmd(16'h5300);
    check("S_txb", 64'(tx_byte), 64'h53);
    tick();
    pulse_done();
    check("S_strm", 64'(streaming), 64'd0);
    tick();

    // 5-byte 'A' frame
    fv_before = fv_count;
    send_rx(8'h41); send_rx(8'h01); send_rx(8'h02); send_rx(8'h03);
    check("A_fv_early", 64'(frame_valid), 64'd0);
    send_rx(8'h04);
    check("A_fv", 64'(frame_valid), 64'd1);
    check("A_frame", 64'(frame), 64'h4101020304);
    tick();
    check("A_fv_once", 64'(frame_valid), 64'd0);
    check("A_hold", 64'(frame), 64'h4101020304);
    check("A_pulses", 64'(fv_count - fv_before), 64'd1);

    // 3-byte 'M' frame immediately followed by an 'A' header
    send_rx(8'h4D); send_rx(8'hAA); send_rx(8'hBB);
    check("M_fv", 64'(frame_valid), 64'd1);
    check("M_frame", 64'(frame), 64'h4DAABB0000);
    send_rx(8'h41); send_rx(8'h05); send_rx(8'h06); send_rx(8'h07); send_rx(8'h08);
    check("A2_frame", 64'(frame), 64'h4105060708);
    check("A2_fv", 64'(frame_valid), 64'd1);

    // 'a' frame with idle gaps between bytes
    tick();
    send_rx(8'h61); repeat (5) tick();
    send_rx(8'h33); repeat (7) tick();
    send_rx(8'h44);
    check("a_frame", 64'(frame), 64'h6133440000);

    // unknown header
    tick();
    fv_before = fv_count;
    err_before = err_count;
    send_rx(8'h58);
    check("bad_err", 64'(rx_err), 64'd1);
    tick();
    check("bad_err_once", 64'(rx_err), 64'd0);
    check("bad_no_fv", 64'(fv_count - fv_before), 64'd0);
    check("bad_err_cnt", 64'(err_count - err_before), 64'd1);
    check("bad_frame_hold", 64'(frame), 64'h6133440000);

`ifdef UART_HOST_RX_TIMEOUT_EN
    send_rx(8'h41); send_rx(8'h01);
    repeat (int'(TMO) - 1) tick();
    check("tmo_not_yet", 64'(rx_err), 64'd0);
    tick();
    check("tmo_err", 64'(rx_err), 64'd1);
    send_rx(8'h41); send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
    check("tmo_recover", 64'(frame), 64'h4111223344);
`endif

    // reset mid-command and mid-frame
    issue_cmd(16'h5200);
    tick();
    pulse_done();
    tick();
    issue_cmd(16'h6D1A);
    send_rx(8'h41); send_rx(8'h01);
    rx_byte = 8'h02; rx_valid = 1'b1; rstn = 1'b0;
    tick();
    rx_valid = 1'b0;
    check_all_zero("midrst");
    tick();
    fv_before = fv_count;
    err_before = err_count;
    rstn = 1'b1;
    tick();
    check("midrst_ready", 64'(cmd_ready), 64'd1);
    repeat (10) tick();
    check("midrst_no_fv", 64'(fv_count - fv_before), 64'd0);
    check("midrst_no_err", 64'(err_count - err_before), 64'd0);
    check("midrst_txv", 64'(tx_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_host_controller.md
UART_HOST_CONTROLLER -- requirements
Module: uart_host_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd2700, inter-byte RX timeout in i_CLK cycles (about 10 byte times at 27 clks/bit).
REQ-002 i_CLK  in  1  single system clock; all logic on rising edge.
REQ-003 i_RSTN  in  1  reset, asynchronous, active-low.
REQ-004 i_CMD  in  16  command: [15:8] signal byte, [7:0] register address (used by 'm'/'a' only).
REQ-005 i_CMD_VALID  in  1  command offered.
REQ-006 o_CMD_READY  out  1  command accepted when high together with i_CMD_VALID.
REQ-007 o_TX_BYTE  out  8  byte to uart_tx.
REQ-008 o_TX_BYTE_VALID  out  1  one-cycle start pulse to uart_tx.
REQ-009 i_TX_DONE  in  1  uart_tx byte-complete pulse.
REQ-010 i_RX_BYTE  in  8  byte from uart_rx.
REQ-011 i_RX_BYTE_VALID  in  1  one-cycle byte-valid pulse from uart_rx.
REQ-012 o_FRAME  out  40  received frame, left-justified, header in [39:32].
REQ-013 o_FRAME_VALID  out  1  one-cycle frame-complete pulse.
REQ-014 o_RX_ERR  out  1  one-cycle pulse on unknown header or timeout abort.
REQ-015 o_STREAMING  out  1  high after 'R' is sent, low after 'S' is sent.

Function
REQ-016 TX and RX paths SHALL run independently and concurrently (full duplex).
REQ-017 TX FSM states SHALL be TX_IDLE, TX_SEND, TX_WAIT, TX_NEXT; o_CMD_READY high only in TX_IDLE.
REQ-018 On accept, 'R','S','F','f' SHALL send 1 byte (the signal); 'm','a' SHALL send 2 bytes (signal, then address); any other signal SHALL be dropped with no byte sent, returning to TX_IDLE the next cycle.
REQ-019 o_TX_BYTE_VALID SHALL pulse exactly one cycle, the cycle after accept (or after the previous i_TX_DONE); o_TX_BYTE SHALL hold until the matching i_TX_DONE.
REQ-020 i_TX_DONE seen outside TX_WAIT SHALL be ignored.
REQ-021 o_STREAMING SHALL update on the i_TX_DONE of the 'R'/'S' byte.
REQ-022 RX FSM states SHALL be RX_IDLE, RX_BODY, RX_DONE; in RX_IDLE a valid byte is the header.
REQ-023 Header 'A' SHALL imply a 5-byte frame; 'M','m','a' SHALL imply a 3-byte frame; any other header SHALL pulse o_RX_ERR next cycle and stay in RX_IDLE.
REQ-024 Bytes SHALL pack MSB-first into [39:0]; for 3-byte frames o_FRAME[15:0] SHALL be 0.
REQ-025 o_FRAME_VALID SHALL pulse the cycle after the last byte; o_FRAME SHALL hold until the next frame completes.
REQ-026 A byte arriving in RX_DONE SHALL be treated as the next header (no byte lost).
REQ-027 Byte counter SHALL be 3 bits and SHALL saturate; it never wraps past the frame length.

Reset
REQ-028 While i_RSTN low: o_CMD_READY=0, o_TX_BYTE=0, o_TX_BYTE_VALID=0, o_FRAME=0, o_FRAME_VALID=0, o_RX_ERR=0, o_STREAMING=0, both FSMs idle, counters 0.
REQ-029 o_CMD_READY SHALL go high the first clock after release.
REQ-030 Reset mid-frame or mid-command SHALL discard the partial transfer with no pulse on release.

Configuration
REQ-031 Macro UART_HOST_RX_TIMEOUT_EN defined: in RX_BODY, TIMEOUT_CYCLES cycles without i_RX_BYTE_VALID SHALL abort the frame, pulse o_RX_ERR and return to RX_IDLE; the counter restarts on each byte.
REQ-032 Macro not defined: no timeout counter exists and RX_BODY waits indefinitely.

Structure
REQ-033 Package uart_host_pkg SHALL hold the signal byte constants ('M','m','A','a','R','S','F','f'), frame lengths and FSM state encodings.
REQ-034 The RX path SHALL be sub-module uart_host_frame_rx; TX FSM stays in the top level.

Verification
REQ-035 i_CMD=16'h5200 accepted, i_TX_DONE after 270 cycles -> one byte 8'h52, o_STREAMING=1, o_CMD_READY high again.
REQ-036 i_CMD=16'h6D1A -> bytes 8'h6D then 8'h1A, second o_TX_BYTE_VALID one cycle after first i_TX_DONE.
REQ-037 RX bytes 41,01,02,03,04 -> o_FRAME=40'h4101020304, one o_FRAME_VALID pulse.
REQ-038 RX bytes 4D,AA,BB then immediately 41 -> o_FRAME=40'h4DAABB0000, then new 'A' frame assembles correctly.
REQ-039 RX header 8'h58 -> o_RX_ERR pulse, no o_FRAME_VALID; with UART_HOST_RX_TIMEOUT_EN, bytes 41,01 then silence -> o_RX_ERR after TIMEOUT_CYCLES.
REQ-040 i_RSTN low during byte 3 of 'A' frame -> all outputs zero, no o_FRAME_VALID after release.
